// File: rtl/octave_mode_ctrl.sv
// Octave / waveform-mode settings controller.
// Consumes one-cycle keypad pulses and keeps a saturating octave counter plus a
// four-state cyclic waveform-mode FSM. Every output is registered, including the
// signed offset from the reset octave, the limit flags and the change strobe.
//
// Mode FSM states:
//   state          | meaning
//   MODE_SQUARE    | square wave (2'b00), reset state
//   MODE_SAW       | sawtooth wave (2'b01)
//   MODE_TRIANGLE  | triangle wave (2'b10)
//   MODE_SINE      | sine wave (2'b11), wraps back to MODE_SQUARE
module octave_mode_ctrl #(
    parameter int OCT_W     = 3,
    parameter int OCT_MIN   = 0,
    parameter int OCT_MAX   = 7,
    parameter int OCT_RESET = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             modekey,
    input  logic             octive_up,
    input  logic             octive_down,
    output logic [OCT_W-1:0] octave,
    output logic [OCT_W:0]   octave_delta,
    output logic [1:0]       mode,
    output logic             at_max,
    output logic             at_min,
    output logic             settings_changed
);

    typedef enum logic [1:0] {
        MODE_SQUARE   = 2'b00,
        MODE_SAW      = 2'b01,
        MODE_TRIANGLE = 2'b10,
        MODE_SINE     = 2'b11
    } mode_t;

    localparam logic [OCT_W-1:0] OCT_MIN_V   = OCT_W'(OCT_MIN);
    localparam logic [OCT_W-1:0] OCT_MAX_V   = OCT_W'(OCT_MAX);
    localparam logic [OCT_W-1:0] OCT_RESET_V = OCT_W'(OCT_RESET);
    // Reset octave widened by one bit so the delta subtraction stays in range.
    localparam logic [OCT_W:0]   OCT_RESET_X = {1'b0, OCT_RESET_V};
    localparam logic             RST_AT_MAX  = (OCT_RESET == OCT_MAX);
    localparam logic             RST_AT_MIN  = (OCT_RESET == OCT_MIN);

    logic [OCT_W-1:0] octave_q, octave_d;
    logic [OCT_W:0]   delta_q, delta_d;
    mode_t            mode_q, mode_d;
    logic             at_max_q, at_max_d;
    logic             at_min_q, at_min_d;
    logic             changed_q, changed_d;

    // Next-state: saturating octave step, cyclic mode advance, derived flags.
    always_comb begin
        octave_d = octave_q;
        mode_d   = mode_q;

        // Simultaneous up and down cancel, so only the exclusive cases move.
        unique case ({octive_up, octive_down})
            2'b10: if (octave_q < OCT_MAX_V) octave_d = octave_q + 1'b1;
            2'b01: if (octave_q > OCT_MIN_V) octave_d = octave_q - 1'b1;
            default: octave_d = octave_q;
        endcase

        if (modekey) begin
            unique case (mode_q)
                MODE_SQUARE:   mode_d = MODE_SAW;
                MODE_SAW:      mode_d = MODE_TRIANGLE;
                MODE_TRIANGLE: mode_d = MODE_SINE;
                default:       mode_d = MODE_SQUARE;
            endcase
        end

        delta_d   = {1'b0, octave_d} - OCT_RESET_X;
        at_max_d  = (octave_d == OCT_MAX_V);
        at_min_d  = (octave_d == OCT_MIN_V);
        // Strobe only on a real value change; saturated or cancelled presses are silent.
        changed_d = (octave_d != octave_q) || (mode_d != mode_q);
    end

    // State and registered outputs; reset overrides any pulse in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            octave_q  <= OCT_RESET_V;
            delta_q   <= '0;
            mode_q    <= MODE_SQUARE;
            at_max_q  <= RST_AT_MAX;
            at_min_q  <= RST_AT_MIN;
            changed_q <= 1'b0;
        end else begin
            octave_q  <= octave_d;
            delta_q   <= delta_d;
            mode_q    <= mode_d;
            at_max_q  <= at_max_d;
            at_min_q  <= at_min_d;
            changed_q <= changed_d;
        end
    end

    assign octave           = octave_q;
    assign octave_delta     = delta_q;
    assign mode             = mode_q;
    assign at_max           = at_max_q;
    assign at_min           = at_min_q;
    assign settings_changed = changed_q;

endmodule

// File: tb/tb_octave_mode_ctrl.sv
// Directed bench for octave_mode_ctrl with default parameters.
module tb_octave_mode_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       modekey = 1'b0;
    logic       octive_up = 1'b0;
    logic       octive_down = 1'b0;
    logic [2:0] octave;
    logic [3:0] octave_delta;
    logic [1:0] mode;
    logic       at_max;
    logic       at_min;
    logic       settings_changed;

    int checks = 0;
    int errors = 0;

    octave_mode_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .modekey          (modekey),
        .octive_up        (octive_up),
        .octive_down      (octive_down),
        .octave           (octave),
        .octave_delta     (octave_delta),
        .mode             (mode),
        .at_max           (at_max),
        .at_min           (at_min),
        .settings_changed (settings_changed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check every output against a hand-supplied octave, mode and strobe.
    // Delta is given explicitly as a 4-bit two's-complement value.
    task automatic chk_all(input string tag, input logic [2:0] e_oct, input logic [3:0] e_delta,
                           input logic [1:0] e_mode, input logic e_max, input logic e_min,
                           input logic e_chg);
        chk({tag, ".octave"}, 32'(octave), 32'(e_oct));
        chk({tag, ".delta"},  32'(octave_delta), 32'(e_delta));
        chk({tag, ".mode"},   32'(mode), 32'(e_mode));
        chk({tag, ".at_max"}, 32'(at_max), 32'(e_max));
        chk({tag, ".at_min"}, 32'(at_min), 32'(e_min));
        chk({tag, ".chg"},    32'(settings_changed), 32'(e_chg));
    endtask

    // Apply one cycle of inputs, then sample just after the sampling edge.
    task automatic cyc(input logic r, input logic up, input logic dn, input logic mk);
        @(negedge clk);
        rst = r; octive_up = up; octive_down = dn; modekey = mk;
        @(posedge clk);
        #1;
        rst = 1'b0; octive_up = 1'b0; octive_down = 1'b0; modekey = 1'b0;
    endtask

    initial begin
        // Reset, then idle
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 1);
        chk_all("reset", 3'd4, 4'h0, 2'b00, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0);
            chk_all("idle", 3'd4, 4'h0, 2'b00, 0, 0, 0);
        end

        // Separate up pulses to saturation
        cyc(0, 1, 0, 0); chk_all("up1", 3'd5, 4'h1, 2'b00, 0, 0, 1);
        cyc(0, 0, 0, 0); chk_all("up1.gap", 3'd5, 4'h1, 2'b00, 0, 0, 0);
        cyc(0, 1, 0, 0); chk_all("up2", 3'd6, 4'h2, 2'b00, 0, 0, 1);
        cyc(0, 0, 0, 0); chk_all("up2.gap", 3'd6, 4'h2, 2'b00, 0, 0, 0);
        cyc(0, 1, 0, 0); chk_all("up3", 3'd7, 4'h3, 2'b00, 1, 0, 1);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0); chk_all("up4.sat", 3'd7, 4'h3, 2'b00, 1, 0, 0);

        // Down pulses to floor
        cyc(1, 0, 0, 0); chk_all("rst2", 3'd4, 4'h0, 2'b00, 0, 0, 0);
        cyc(0, 0, 1, 0); chk_all("dn1", 3'd3, 4'hF, 2'b00, 0, 0, 1);
        cyc(0, 0, 1, 0); chk_all("dn2", 3'd2, 4'hE, 2'b00, 0, 0, 1);
        cyc(0, 0, 1, 0); chk_all("dn3", 3'd1, 4'hD, 2'b00, 0, 0, 1);
        cyc(0, 0, 1, 0); chk_all("dn4", 3'd0, 4'b1100, 2'b00, 0, 1, 1);
        cyc(0, 0, 1, 0); chk_all("dn5.sat", 3'd0, 4'b1100, 2'b00, 0, 1, 0);

        // Cancel, and combined mode+octave update
        cyc(1, 0, 0, 0);
        cyc(0, 1, 1, 0); chk_all("cancel", 3'd4, 4'h0, 2'b00, 0, 0, 0);
        cyc(0, 1, 0, 1); chk_all("mk+up", 3'd5, 4'h1, 2'b01, 0, 0, 1);
        cyc(0, 0, 0, 0); chk_all("mk+up.after", 3'd5, 4'h1, 2'b01, 0, 0, 0);

        // Mode cycling with separate pulses, then held modekey
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 1); chk_all("mk1", 3'd4, 4'h0, 2'b01, 0, 0, 1);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1); chk_all("mk2", 3'd4, 4'h0, 2'b10, 0, 0, 1);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1); chk_all("mk3", 3'd4, 4'h0, 2'b11, 0, 0, 1);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1); chk_all("mk4.wrap", 3'd4, 4'h0, 2'b00, 0, 0, 1);
        cyc(0, 0, 0, 1); chk_all("held1", 3'd4, 4'h0, 2'b01, 0, 0, 1);
        cyc(0, 0, 0, 1); chk_all("held2", 3'd4, 4'h0, 2'b10, 0, 0, 1);
        cyc(0, 0, 0, 1); chk_all("held3", 3'd4, 4'h0, 2'b11, 0, 0, 1);
        cyc(0, 0, 0, 0); chk_all("held.after", 3'd4, 4'h0, 2'b11, 0, 0, 0);

        // Back-to-back up pulses, reset overriding a pending pulse
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 1); chk_all("b2b1", 3'd5, 4'h1, 2'b01, 0, 0, 1);
        cyc(0, 1, 0, 1); chk_all("b2b2", 3'd6, 4'h2, 2'b10, 0, 0, 1);
        cyc(1, 1, 0, 0); chk_all("rst.override", 3'd4, 4'h0, 2'b00, 0, 0, 0);
        cyc(0, 0, 0, 0); chk_all("release.idle", 3'd4, 4'h0, 2'b00, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0); chk_all("release.pulse", 3'd5, 4'h1, 2'b00, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
